// File: rtl/switch_rr_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : switch_rr_arbiter_pkg
// Purpose  : Shared types and helpers for the round-robin switch arbiter.
//            arb_state_t  - arbiter FSM state encoding
//            rr_next_idx  - round-robin index advance with wrap N-1 -> 0
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package switch_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Next requester index after cur, wrapping to 0 after n-1.
  function automatic int rr_next_idx(input int cur, input int n);
    return (cur >= n - 1) ? 0 : cur + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_rr_prio_enc.sv
//------------------------------------------------------------------------------
// Module   : switch_rr_prio_enc
// Purpose  : Combinational rotating priority encoder. Returns the first set
//            bit of vld scanning upward from ptr, wrapping N_INPUTS-1 -> 0.
// Ports    : vld  in  N_INPUTS   request vector
//            ptr  in  SEL_WIDTH  scan start index (0..N_INPUTS-1)
//            idx  out SEL_WIDTH  winning index (0 when none set)
//            any  out 1          at least one request set
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module switch_rr_prio_enc
  import switch_rr_arbiter_pkg::*;
#(
  parameter int N_INPUTS  = 3,
  parameter int SEL_WIDTH = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0]  vld,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 any
);

  // Offsets are visited from farthest to nearest so the nearest set bit
  // (highest priority) is the last one written.
  always_comb begin
    int w_k;
    idx = '0;
    any = 1'b0;
    w_k = 0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      w_k = int'(ptr) + i;
      if (w_k >= N_INPUTS) w_k = w_k - N_INPUTS;
      if (vld[w_k]) begin
        idx = SEL_WIDTH'(w_k);
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/switch_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : switch_rr_arbiter
// Purpose  : Round-robin arbiter/sequencer for an N:1 select multiplexer.
//            Shares one registered output stream among N valid/ready
//            requesters and drives the mux select.
// Config   : SWITCH_RR_ARB_PKT_LOCK_EN - when defined, a grant is held until
//            the beat carrying din_last is accepted (packets never
//            interleave). Otherwise the grant is released after every beat.
// Ports    : clk, rst_n (async active-low)
//            din_data/din_last/din_vld  in   requester payload/eop/valid
//            din_rd                     out  per-requester ready (one-hot0)
//            dout_data/dout_last/dout_vld out registered output beat
//            dout_rd                    in   sink ready
//            sel                        out  current grant index
//            busy                       out  high while in GRANT state
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module switch_rr_arbiter
  import switch_rr_arbiter_pkg::*;
#(
  parameter  int N_INPUTS   = 3,
  parameter  int DATA_WIDTH = 8,
  localparam int SEL_WIDTH  = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] din_data,
  input  logic [N_INPUTS-1:0]            din_last,
  input  logic [N_INPUTS-1:0]            din_vld,
  output logic [N_INPUTS-1:0]            din_rd,
  output logic [DATA_WIDTH-1:0]          dout_data,
  output logic                           dout_last,
  output logic                           dout_vld,
  input  logic                           dout_rd,
  output logic [SEL_WIDTH-1:0]           sel,
  output logic                           busy
);

  arb_state_t            r_state, w_state_nxt;
  logic [SEL_WIDTH-1:0]  r_sel, w_sel_nxt;
  logic [SEL_WIDTH-1:0]  r_ptr, w_ptr_nxt;
  logic [SEL_WIDTH-1:0]  w_win_idx;
  logic                  w_win_any;
  logic                  w_out_acc;
  logic                  w_in_hs;
  logic                  w_release;
  logic [DATA_WIDTH-1:0] r_dout_data;
  logic                  r_dout_last;
  logic                  r_dout_vld;

  switch_rr_prio_enc #(
    .N_INPUTS  (N_INPUTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_prio_enc (
    .vld (din_vld),
    .ptr (r_ptr),
    .idx (w_win_idx),
    .any (w_win_any)
  );

  assign busy      = (r_state == ARB_GRANT);
  // Output register can take a new beat when empty or being drained.
  assign w_out_acc = !r_dout_vld || dout_rd;
  assign w_in_hs   = busy && w_out_acc && din_vld[r_sel];

`ifdef SWITCH_RR_ARB_PKT_LOCK_EN
  assign w_release = w_in_hs && din_last[r_sel];
`else
  assign w_release = w_in_hs;
`endif

  always_comb begin
    din_rd = '0;
    if (busy && w_out_acc) din_rd[r_sel] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (w_win_any) begin
          w_state_nxt = ARB_GRANT;
          w_sel_nxt   = w_win_idx;
        end
      end
      ARB_GRANT: begin
        // A request arriving with the release is picked up by the next
        // IDLE cycle, from the advanced pointer, so fairness is preserved.
        if (w_release) begin
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = SEL_WIDTH'(rr_next_idx(int'(r_sel), N_INPUTS));
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_data <= '0;
      r_dout_last <= 1'b0;
      r_dout_vld  <= 1'b0;
    end else if (w_out_acc) begin
      r_dout_vld <= w_in_hs;
      if (w_in_hs) begin
        r_dout_data <= din_data[r_sel*DATA_WIDTH +: DATA_WIDTH];
        r_dout_last <= din_last[r_sel];
      end
    end
  end

  assign dout_data = r_dout_data;
  assign dout_last = r_dout_last;
  assign dout_vld  = r_dout_vld;
  assign sel       = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_switch_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_switch_rr_arbiter
// Purpose  : Self-checking bench for switch_rr_arbiter (N=3, DATA_WIDTH=8).
//            Per-port beat lists are loaded up front; a reference model
//            derives the round-robin output order and pushes it into a
//            scoreboard queue that a monitor checks against dout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_switch_rr_arbiter;

`ifdef SWITCH_RR_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [23:0] din_data;
  logic [2:0]  din_last;
  logic [2:0]  din_vld;
  logic [2:0]  din_rd;
  logic [7:0]  dout_data;
  logic        dout_last;
  logic        dout_vld;
  logic        dout_rd;
  logic [1:0]  sel;
  logic        busy;

  switch_rr_arbiter #(.N_INPUTS(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_data(din_data), .din_last(din_last), .din_vld(din_vld), .din_rd(din_rd),
    .dout_data(dout_data), .dout_last(dout_last), .dout_vld(dout_vld), .dout_rd(dout_rd),
    .sel(sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // beat = {last, data}
  logic [8:0] beats [3][64];
  int         cnt [3];
  int         hd  [3];
  logic [8:0] expq [$];
  int         checks = 0;
  int         failures = 0;
  int         mptr = 0;
  bit         stall = 1'b0;
  bit         bp_rand = 1'b0;

  // Reference model: repeatedly pick the first non-empty requester at or
  // after the pointer; it sends one beat (or one whole packet when locked).
  task automatic model_push();
    int mh [3];
    int w;
    bit done;
    for (int i = 0; i < 3; i++) mh[i] = hd[i];
    forever begin
      w = -1;
      for (int off = 2; off >= 0; off--)
        if (mh[(mptr + off) % 3] < cnt[(mptr + off) % 3]) w = (mptr + off) % 3;
      if (w < 0) break;
      done = 1'b0;
      while (!done) begin
        expq.push_back(beats[w][mh[w]]);
        done = !LOCK || beats[w][mh[w]][8] || (mh[w] + 1 >= cnt[w]);
        mh[w]++;
      end
      mptr = (w + 1) % 3;
    end
  endtask

  task automatic load_random(input logic [2:0] mask);
    int n;
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      hd[i]  = 0;
      if (mask[i]) begin
        for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
          n = $urandom_range(1, 3);
          for (int b = 0; b < n; b++) begin
            beats[i][cnt[i]] = {(b == n - 1), 2'(i), 6'($urandom)};
            cnt[i]++;
          end
        end
      end
    end
    model_push();
  endtask

  // Driver: a beat offered while din_rd is high is consumed at the edge.
  initial begin
    bit hs [3];
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) hs[i] = rst_n && din_rd[i] && din_vld[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (hs[i] && hd[i] < cnt[i]) hd[i]++;
        if (hd[i] < cnt[i]) begin
          din_vld[i]          = 1'b1;
          din_data[i*8 +: 8]  = beats[i][hd[i]][7:0];
          din_last[i]         = beats[i][hd[i]][8];
        end else begin
          din_vld[i]          = 1'b0;
          din_data[i*8 +: 8]  = 8'h00;
          din_last[i]         = 1'b0;
        end
      end
      dout_rd = stall ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor / scoreboard
  initial begin
    bit         have_prev;
    logic [7:0] pd;
    logic       pl;
    logic [8:0] e;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 1'b0;
      end else begin
        checks++;
        if ($countones(din_rd) > 1) begin
          failures++;
          $display("FAIL din_rd_onehot: got %b required at most one bit set", din_rd);
        end
        if (have_prev) begin
          checks++;
          if (dout_vld !== 1'b1 || dout_data !== pd || dout_last !== pl) begin
            failures++;
            $display("FAIL hold: got vld=%b data=%h last=%b required vld=1 data=%h last=%b",
                     dout_vld, dout_data, dout_last, pd, pl);
          end
        end
        have_prev = dout_vld && !dout_rd;
        pd = dout_data;
        pl = dout_last;
        if (dout_vld && dout_rd) begin
          checks++;
          if (expq.size() == 0) begin
            failures++;
            $display("FAIL beat: got unexpected beat data=%h last=%b required none", dout_data, dout_last);
          end else begin
            e = expq.pop_front();
            if (dout_data !== e[7:0] || dout_last !== e[8]) begin
              failures++;
              $display("FAIL beat: got data=%h last=%b required data=%h last=%b",
                       dout_data, dout_last, e[7:0], e[8]);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      ok = (hd[0] == cnt[0]) && (hd[1] == cnt[1]) && (hd[2] == cnt[2]) &&
           (expq.size() == 0) && !dout_vld && !busy;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_drain: got %0d beats outstanding required 0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic wait_busy(input string name, input logic [1:0] req_sel);
    for (int c = 0; c < 50 && !busy; c++) @(negedge clk);
    check(name, {busy, 6'd0, sel}, {1'b1, 6'd0, req_sel});
  endtask

  task automatic clear_ports();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      hd[i]  = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0; din_data = '0; din_last = '0; din_vld = '0; dout_rd = 1'b1;
    clear_ports();

    // Reset held with every requester valid
    for (int i = 0; i < 3; i++) begin
      beats[i][0] = {1'b1, 2'(i), 6'h15};
      cnt[i] = 1;
    end
    model_push();
    repeat (3) @(negedge clk);
    check("rst_dout_vld", 32'(dout_vld), 32'd0);
    check("rst_din_rd", 32'(din_rd), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout_data", 32'(dout_data), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_busy("first_grant", 2'd0);
    drain("all_three");

    // Single requester on port 1
    clear_ports();
    beats[1][0] = {1'b1, 8'h5A};
    cnt[1] = 1;
    model_push();
    wait_busy("single_sel", 2'd1);
    drain("single");

    // Backpressure on a held beat
    clear_ports();
    stall = 1'b1;
    beats[0][0] = {1'b1, 8'h33};
    cnt[0] = 1;
    model_push();
    for (int c = 0; c < 50 && !dout_vld; c++) @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      check("stall_vld", 32'(dout_vld), 32'd1);
      check("stall_data", 32'(dout_data), 32'h33);
      check("stall_din_rd", 32'(din_rd), 32'd0);
    end
    stall = 1'b0;
    drain("stall");

    // Port 2 three-beat packet racing a port 0 packet
    clear_ports();
    beats[2][0] = {1'b0, 8'hC1}; beats[2][1] = {1'b0, 8'hC2}; beats[2][2] = {1'b1, 8'hC3};
    cnt[2] = 3;
    beats[0][0] = {1'b0, 8'h01}; beats[0][1] = {1'b1, 8'h02};
    cnt[0] = 2;
    model_push();
    drain("pkt_race");

    // Randomized phases with random backpressure
    bp_rand = 1'b1;
    repeat (12) begin
      logic [2:0] m;
      m = 3'($urandom_range(1, 7));
      load_random(m);
      drain("random");
    end

    // Reset in the middle of traffic
    load_random(3'b111);
    repeat (5) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("mid_rst_dout_vld", 32'(dout_vld), 32'd0);
    check("mid_rst_din_rd", 32'(din_rd), 32'd0);
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dout_data", 32'(dout_data), 32'd0);
    check("mid_rst_dout_last", 32'(dout_last), 32'd0);
    clear_ports();
    expq.delete();
    mptr = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    load_random(3'b111);
    wait_busy("restart_grant", 2'd0);
    drain("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
